// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the N-phase core cycle sequencer.
// Holds the run-state enum and phase-range constants.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    RUNNING      = 2'd0,
    HALT_PENDING = 2'd1,
    HALTED       = 2'd2
  } seq_state_e;

  localparam int MAX_PHASES  = 16;
  localparam int FETCH_PHASE = 0;

endpackage

// File: rtl/phase_onehot_decoder.sv
// Phase index to one-hot decoder with enable.
// Output is all zero when en is low.
module phase_onehot_decoder #(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_W    = $clog2(NUM_PHASES)
) (
  input  logic [PHASE_W-1:0]    idx,
  input  logic                  en,
  output logic [NUM_PHASES-1:0] onehot
);

  // Set the single bit matching idx while enabled
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (en && idx == PHASE_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// N-phase core cycle sequencer with stall, jump, halt-at-boundary, resume.
// Optional retired-instruction counter: define PHASE_SEQ_RETIRE_CNT_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_W    = $clog2(NUM_PHASES),
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  jump,
  input  logic [PHASE_W-1:0]    jump_phase,
  input  logic                  stall,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic                  is_fetch,
  output logic                  halted,
  output logic                  wrap,
  output logic                  jump_err,
  output logic [CNT_W-1:0]      instr_count
);

  if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES) begin : g_bad_np
    $error("phase_sequencer: NUM_PHASES out of range");
  end

  localparam logic [PHASE_W-1:0] LAST  = PHASE_W'(NUM_PHASES - 1);
  localparam logic [PHASE_W-1:0] FETCH = PHASE_W'(FETCH_PHASE);
  localparam logic [PHASE_W:0]   NP    = (PHASE_W + 1)'(NUM_PHASES);

  seq_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic               jump_err_q, jump_err_d;
  logic               jump_ok;

  assign jump_ok = {1'b0, jump_phase} < NP;

  // Next state: halt handling, then stall > jump > advance > hold
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wrap_d     = 1'b0;
    jump_err_d = jump_err_q;
    unique case (state_q)
      HALTED: begin
        phase_d = FETCH;
        if (resume) state_d = RUNNING;
      end
      default: begin
        if (state_q == RUNNING && halt_req) begin
          state_d = HALT_PENDING;
        end
        if (!stall) begin
          if (jump) begin
            if (jump_ok) phase_d = jump_phase;
            else jump_err_d = 1'b1;
          end else if (advance) begin
            if (phase_q == LAST) begin
              phase_d = FETCH;
              wrap_d  = 1'b1;
              if (state_q == HALT_PENDING) state_d = HALTED;
            end else begin
              phase_d = phase_q + PHASE_W'(1);
            end
          end
        end
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUNNING;
      phase_q    <= FETCH;
      wrap_q     <= 1'b0;
      jump_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wrap_q     <= wrap_d;
      jump_err_q <= jump_err_d;
    end
  end

`ifdef PHASE_SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count one retired instruction per wrap, modulo 2^CNT_W
  always_comb begin
    cnt_d = cnt_q;
    if (wrap_d) cnt_d = cnt_q + CNT_W'(1);
  end

  // Retire counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

  assign phase    = phase_q;
  assign halted   = (state_q == HALTED);
  assign is_fetch = (phase_q == FETCH) && !halted;
  assign wrap     = wrap_q;
  assign jump_err = jump_err_q;

  phase_onehot_decoder #(
    .NUM_PHASES (NUM_PHASES),
    .PHASE_W    (PHASE_W)
  ) u_dec (
    .idx    (phase_q),
    .en     (!halted),
    .onehot (phase_onehot)
  );

endmodule
